// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register specifier, forwarding select codes
// and hazard-unit FSM states.
package lc3b_types;

  localparam int unsigned LC3B_REG_W = 3;

  typedef logic [LC3B_REG_W-1:0] lc3b_reg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10,
    FWD_HIST  = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_LU_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding priority mux: EX/MEM > MEM/WB > WB-history > regfile.
// Ports:
//   src, src_used                 operand specifier and whether it is read
//   exmem_write/is_load/dest      EX/MEM producer
//   memwb_write/dest              MEM/WB producer
//   hist_valid/dest               one-entry writeback history
//   sel_c                         combinational operand select (fwd_sel_t code)
module fwd_select
  import lc3b_types::*;
#(
  parameter int unsigned REG_W   = 3,
  parameter bit          HIST_EN = 1'b1
) (
  input  logic [REG_W-1:0] src,
  input  logic             src_used,
  input  logic             exmem_write,
  input  logic             exmem_is_load,
  input  logic [REG_W-1:0] exmem_dest,
  input  logic             memwb_write,
  input  logic [REG_W-1:0] memwb_dest,
  input  logic             hist_valid,
  input  logic [REG_W-1:0] hist_dest,
  output logic [1:0]       sel_c
);

  // A load in EX/MEM has no data yet; that case is covered by the load-use stall.
  always_comb begin
    sel_c = FWD_RF;
    if (src_used) begin
      if (exmem_write && !exmem_is_load && (exmem_dest == src)) begin
        sel_c = FWD_EXMEM;
      end else if (memwb_write && (memwb_dest == src)) begin
        sel_c = FWD_MEMWB;
      end else if (HIST_EN && hist_valid && (hist_dest == src)) begin
        sel_c = FWD_HIST;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use stall sequencing, memory-wait freeze and a
// saturating stall-cycle counter for the ID/EX boundary.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   ex_sr1/2, ex_sr1/2_used           EX operand specifiers
//   id_valid, id_sr1/2, id_sr1/2_used ID operand specifiers
//   idex_*, exmem_*, memwb_*          in-flight producers
//   mem_busy                          memory stage waiting
//   perf_clr                          clear stall_count
//   fwd_a, fwd_b                      ALU operand selects
//   hold_front, bubble_ex, hold_all   pipeline-register controls
//   stall_count                       saturating stalled-cycle count
module fwd_hazard_unit
  import lc3b_types::*;
#(
  parameter int unsigned REG_W            = 3,
  parameter int unsigned LOAD_USE_CYCLES  = 1,
  parameter int unsigned RF_WRITE_THROUGH = 0,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] ex_sr1,
  input  logic [REG_W-1:0] ex_sr2,
  input  logic             ex_sr1_used,
  input  logic             ex_sr2_used,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_sr1,
  input  logic [REG_W-1:0] id_sr2,
  input  logic             id_sr1_used,
  input  logic             id_sr2_used,
  input  logic             idex_write,
  input  logic             idex_is_load,
  input  logic [REG_W-1:0] idex_dest,
  input  logic             exmem_write,
  input  logic             exmem_is_load,
  input  logic [REG_W-1:0] exmem_dest,
  input  logic             memwb_write,
  input  logic [REG_W-1:0] memwb_dest,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             hold_front,
  output logic             bubble_ex,
  output logic             hold_all,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned LU_CNT_W  = 3;
  localparam int unsigned LU_RELOAD = (LOAD_USE_CYCLES > 1) ? LOAD_USE_CYCLES - 2 : 0;
  localparam bit          HIST_EN   = (RF_WRITE_THROUGH == 0);

  hz_state_t           state, next_state;
  logic [LU_CNT_W-1:0] lu_cnt, next_lu_cnt;
  logic                hist_valid;
  logic [REG_W-1:0]    hist_dest;
  logic [1:0]          fwd_a_c, fwd_b_c;
  logic                lu_hit_c;
  logic                hold_front_c, bubble_ex_c, hold_all_c;

  // Operand forwarding muxes
  fwd_select #(.REG_W(REG_W), .HIST_EN(HIST_EN)) u_fwd_a (
    .src           (ex_sr1),
    .src_used      (ex_sr1_used),
    .exmem_write   (exmem_write),
    .exmem_is_load (exmem_is_load),
    .exmem_dest    (exmem_dest),
    .memwb_write   (memwb_write),
    .memwb_dest    (memwb_dest),
    .hist_valid    (hist_valid),
    .hist_dest     (hist_dest),
    .sel_c         (fwd_a_c)
  );

  fwd_select #(.REG_W(REG_W), .HIST_EN(HIST_EN)) u_fwd_b (
    .src           (ex_sr2),
    .src_used      (ex_sr2_used),
    .exmem_write   (exmem_write),
    .exmem_is_load (exmem_is_load),
    .exmem_dest    (exmem_dest),
    .memwb_write   (memwb_write),
    .memwb_dest    (memwb_dest),
    .hist_valid    (hist_valid),
    .hist_dest     (hist_dest),
    .sel_c         (fwd_b_c)
  );

  // Load in EX feeding an operand of the instruction in ID
  assign lu_hit_c = id_valid && idex_write && idex_is_load &&
                    ((id_sr1_used && (id_sr1 == idex_dest)) ||
                     (id_sr2_used && (id_sr2 == idex_dest)));

  // Hazard FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= HZ_RUN;
      lu_cnt <= '0;
    end else begin
      state  <= next_state;
      lu_cnt <= next_lu_cnt;
    end
  end

  // Next state and stall controls; a memory wait freezes the FSM in place
  always_comb begin
    next_state   = state;
    next_lu_cnt  = lu_cnt;
    hold_front_c = 1'b0;
    bubble_ex_c  = 1'b0;
    hold_all_c   = 1'b0;
    if (mem_busy) begin
      hold_all_c = 1'b1;
    end else begin
      case (state)
        HZ_RUN: begin
          if (lu_hit_c) begin
            hold_front_c = 1'b1;
            bubble_ex_c  = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              next_lu_cnt = LU_CNT_W'(LU_RELOAD);
              next_state  = HZ_LU_WAIT;
            end
          end
        end
        HZ_LU_WAIT: begin
          hold_front_c = 1'b1;
          bubble_ex_c  = 1'b1;
          if (lu_cnt == '0) begin
            next_state = HZ_RUN;
          end else begin
            next_lu_cnt = lu_cnt - LU_CNT_W'(1);
          end
        end
        default: next_state = HZ_RUN;
      endcase
    end
  end

  // Reset forces every combinational output low immediately
  assign fwd_a      = reset_n ? fwd_a_c : 2'b00;
  assign fwd_b      = reset_n ? fwd_b_c : 2'b00;
  assign hold_front = reset_n & hold_front_c;
  assign bubble_ex  = reset_n & bubble_ex_c;
  assign hold_all   = reset_n & hold_all_c;

  // Writeback history: remembers the last retired destination for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_valid <= 1'b0;
      hist_dest  <= '0;
    end else if (!hold_all_c) begin
      hist_valid <= memwb_write;
      hist_dest  <= memwb_dest;
    end
  end

  // Saturating stalled-cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (perf_clr) begin
      stall_count <= '0;
    end else if ((hold_front_c || hold_all_c) && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic       clk, reset_n;
  logic [2:0] ex_sr1, ex_sr2, id_sr1, id_sr2, idex_dest, exmem_dest, memwb_dest;
  logic       ex_sr1_used, ex_sr2_used, id_valid, id_sr1_used, id_sr2_used;
  logic       idex_write, idex_is_load, exmem_write, exmem_is_load, memwb_write;
  logic       mem_busy, perf_clr;

  logic [1:0]  fwd_a, fwd_b, wt_fwd_a, wt_fwd_b;
  logic        hold_front, bubble_ex, hold_all;
  logic        wt_hold_front, wt_bubble_ex, wt_hold_all;
  logic [15:0] stall_count;
  logic [2:0]  wt_stall_count;

  int total = 0;
  int bad   = 0;

  // Main instance: 3-cycle load-use, WB-history enabled
  fwd_hazard_unit #(.REG_W(3), .LOAD_USE_CYCLES(3), .RF_WRITE_THROUGH(0), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_sr1(ex_sr1), .ex_sr2(ex_sr2), .ex_sr1_used(ex_sr1_used), .ex_sr2_used(ex_sr2_used),
    .id_valid(id_valid), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
    .idex_write(idex_write), .idex_is_load(idex_is_load), .idex_dest(idex_dest),
    .exmem_write(exmem_write), .exmem_is_load(exmem_is_load), .exmem_dest(exmem_dest),
    .memwb_write(memwb_write), .memwb_dest(memwb_dest),
    .mem_busy(mem_busy), .perf_clr(perf_clr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .hold_front(hold_front), .bubble_ex(bubble_ex),
    .hold_all(hold_all), .stall_count(stall_count)
  );

  // Second instance: 1-cycle load-use, write-through regfile, 3-bit counter
  fwd_hazard_unit #(.REG_W(3), .LOAD_USE_CYCLES(1), .RF_WRITE_THROUGH(1), .CNT_W(3)) dut_wt (
    .clk(clk), .reset_n(reset_n),
    .ex_sr1(ex_sr1), .ex_sr2(ex_sr2), .ex_sr1_used(ex_sr1_used), .ex_sr2_used(ex_sr2_used),
    .id_valid(id_valid), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
    .idex_write(idex_write), .idex_is_load(idex_is_load), .idex_dest(idex_dest),
    .exmem_write(exmem_write), .exmem_is_load(exmem_is_load), .exmem_dest(exmem_dest),
    .memwb_write(memwb_write), .memwb_dest(memwb_dest),
    .mem_busy(mem_busy), .perf_clr(perf_clr),
    .fwd_a(wt_fwd_a), .fwd_b(wt_fwd_b), .hold_front(wt_hold_front), .bubble_ex(wt_bubble_ex),
    .hold_all(wt_hold_all), .stall_count(wt_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ex_sr1 = '0; ex_sr2 = '0; ex_sr1_used = 0; ex_sr2_used = 0;
    id_valid = 0; id_sr1 = '0; id_sr2 = '0; id_sr1_used = 0; id_sr2_used = 0;
    idex_write = 0; idex_is_load = 0; idex_dest = '0;
    exmem_write = 0; exmem_is_load = 0; exmem_dest = '0;
    memwb_write = 0; memwb_dest = '0;
    mem_busy = 0; perf_clr = 0;
  endtask

  task automatic test_reset;
    reset_n = 0;
    clear_inputs();
    exmem_write = 1; exmem_dest = 3'd0; ex_sr1 = 3'd0; ex_sr1_used = 1;
    mem_busy = 1;
    #1;
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL reset_fwd_a: got %b expected 00", fwd_a); end
    total++; if (hold_all !== 1'b0) begin bad++; $display("FAIL reset_hold_all: got %b expected 0", hold_all); end
    total++; if (wt_hold_all !== 1'b0) begin bad++; $display("FAIL reset_wt_hold_all: got %b expected 0", wt_hold_all); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall_count: got %0d expected 0", stall_count); end
    repeat (2) tick();
    clear_inputs();
    reset_n = 1;
    #1;
    total++; if (hold_front !== 1'b0) begin bad++; $display("FAIL post_reset_hold_front: got %b expected 0", hold_front); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL post_reset_stall_count: got %0d expected 0", stall_count); end
  endtask

  task automatic test_forwarding;
    clear_inputs();
    exmem_write = 1; exmem_dest = 3'd3; memwb_write = 1; memwb_dest = 3'd3;
    ex_sr1 = 3'd3; ex_sr2 = 3'd3; ex_sr1_used = 1; ex_sr2_used = 1;
    #1;
    total++; if (fwd_a !== 2'b10) begin bad++; $display("FAIL fwd_exmem_a: got %b expected 10", fwd_a); end
    total++; if (fwd_b !== 2'b10) begin bad++; $display("FAIL fwd_exmem_b: got %b expected 10", fwd_b); end
    exmem_is_load = 1;
    #1;
    total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_load_skips_exmem: got %b expected 01", fwd_a); end
    clear_inputs();
    ex_sr1 = 3'd1; ex_sr1_used = 1; ex_sr2 = 3'd4; ex_sr2_used = 0;
    memwb_write = 1; memwb_dest = 3'd4;
    #1;
    total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_imm_unused: got %b expected 00", fwd_b); end
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL fwd_no_match: got %b expected 00", fwd_a); end
    ex_sr2_used = 1;
    #1;
    total++; if (fwd_b !== 2'b01) begin bad++; $display("FAIL fwd_memwb_b: got %b expected 01", fwd_b); end
    total++; if (wt_fwd_b !== 2'b01) begin bad++; $display("FAIL wt_fwd_memwb_b: got %b expected 01", wt_fwd_b); end
    clear_inputs();
  endtask

  task automatic test_hist;
    clear_inputs();
    memwb_write = 1; memwb_dest = 3'd5;
    tick();
    memwb_write = 0; memwb_dest = 3'd0;
    ex_sr1 = 3'd5; ex_sr1_used = 1; ex_sr2 = 3'd5; ex_sr2_used = 0;
    #1;
    total++; if (fwd_a !== 2'b11) begin bad++; $display("FAIL hist_fwd_a: got %b expected 11", fwd_a); end
    total++; if (wt_fwd_a !== 2'b00) begin bad++; $display("FAIL hist_wt_disabled: got %b expected 00", wt_fwd_a); end
    total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL hist_unused_b: got %b expected 00", fwd_b); end
    memwb_write = 1; memwb_dest = 3'd5;
    #1;
    total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL hist_below_memwb: got %b expected 01", fwd_a); end
    clear_inputs();
    tick();
    ex_sr1 = 3'd5; ex_sr1_used = 1;
    #1;
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL hist_expired: got %b expected 00", fwd_a); end
    clear_inputs();
  endtask

  task automatic test_load_use;
    clear_inputs();
    id_valid = 1; id_sr1 = 3'd7; id_sr1_used = 1; id_sr2 = 3'd2; id_sr2_used = 1;
    idex_write = 1; idex_is_load = 0; idex_dest = 3'd2;
    #1;
    total++; if (hold_front !== 1'b0) begin bad++; $display("FAIL lu_non_load: got %b expected 0", hold_front); end
    idex_is_load = 1;
    #1;
    total++; if ({hold_front, bubble_ex} !== 2'b11) begin bad++; $display("FAIL lu_bubble_0: got %b expected 11", {hold_front, bubble_ex}); end
    total++; if (wt_hold_front !== 1'b1) begin bad++; $display("FAIL lu_wt_bubble: got %b expected 1", wt_hold_front); end
    tick();
    idex_write = 0; idex_is_load = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({hold_front, bubble_ex} !== 2'b11) begin bad++; $display("FAIL lu_bubble_%0d: got %b expected 11", i + 1, {hold_front, bubble_ex}); end
      if (i == 0) begin
        total++; if (wt_hold_front !== 1'b0) begin bad++; $display("FAIL lu_wt_single: got %b expected 0", wt_hold_front); end
      end
      tick();
    end
    #1;
    total++; if ({hold_front, bubble_ex} !== 2'b00) begin bad++; $display("FAIL lu_done: got %b expected 00", {hold_front, bubble_ex}); end
    total++; if (stall_count !== 16'd3) begin bad++; $display("FAIL lu_stall_count: got %0d expected 3", stall_count); end
    total++; if (wt_stall_count !== 3'd1) begin bad++; $display("FAIL lu_wt_stall_count: got %0d expected 1", wt_stall_count); end
    clear_inputs();
  endtask

  task automatic test_mem_busy;
    clear_inputs();
    perf_clr = 1;
    tick();
    perf_clr = 0;
    #1;
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL mb_clr: got %0d expected 0", stall_count); end
    total++; if (wt_stall_count !== 3'd0) begin bad++; $display("FAIL mb_wt_clr: got %0d expected 0", wt_stall_count); end
    id_valid = 1; id_sr1 = 3'd2; id_sr1_used = 1;
    idex_write = 1; idex_is_load = 1; idex_dest = 3'd2;
    #1;
    total++; if (hold_front !== 1'b1) begin bad++; $display("FAIL mb_first_bubble: got %b expected 1", hold_front); end
    tick();
    idex_write = 0; idex_is_load = 0;
    mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if ({hold_all, hold_front, bubble_ex} !== 3'b100) begin bad++; $display("FAIL mb_freeze_%0d: got %b expected 100", i, {hold_all, hold_front, bubble_ex}); end
      tick();
    end
    mem_busy = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({hold_all, hold_front, bubble_ex} !== 3'b011) begin bad++; $display("FAIL mb_resume_%0d: got %b expected 011", i, {hold_all, hold_front, bubble_ex}); end
      tick();
    end
    #1;
    total++; if ({hold_all, hold_front, bubble_ex} !== 3'b000) begin bad++; $display("FAIL mb_done: got %b expected 000", {hold_all, hold_front, bubble_ex}); end
    total++; if (stall_count !== 16'd7) begin bad++; $display("FAIL mb_stall_count: got %0d expected 7", stall_count); end
    total++; if (wt_stall_count !== 3'd5) begin bad++; $display("FAIL mb_wt_stall_count: got %0d expected 5", wt_stall_count); end
    clear_inputs();
  endtask

  task automatic test_saturation;
    clear_inputs();
    mem_busy = 1;
    repeat (6) tick();
    mem_busy = 0;
    #1;
    total++; if (stall_count !== 16'd13) begin bad++; $display("FAIL sat_count: got %0d expected 13", stall_count); end
    total++; if (wt_stall_count !== 3'd7) begin bad++; $display("FAIL sat_wt_count: got %0d expected 7", wt_stall_count); end
    perf_clr = 1; mem_busy = 1;
    tick();
    perf_clr = 0; mem_busy = 0;
    #1;
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL clr_priority: got %0d expected 0", stall_count); end
    total++; if (wt_stall_count !== 3'd0) begin bad++; $display("FAIL clr_wt_priority: got %0d expected 0", wt_stall_count); end
  endtask

  task automatic test_reset_mid_stall;
    clear_inputs();
    id_valid = 1; id_sr2 = 3'd6; id_sr2_used = 1;
    idex_write = 1; idex_is_load = 1; idex_dest = 3'd6;
    #1;
    total++; if (hold_front !== 1'b1) begin bad++; $display("FAIL rms_first: got %b expected 1", hold_front); end
    tick();
    idex_write = 0; idex_is_load = 0;
    #1;
    total++; if (hold_front !== 1'b1) begin bad++; $display("FAIL rms_lu_wait: got %b expected 1", hold_front); end
    #2;
    exmem_write = 1; exmem_dest = 3'd1; ex_sr1 = 3'd1; ex_sr1_used = 1;
    reset_n = 0;
    #1;
    total++; if ({hold_all, hold_front, bubble_ex} !== 3'b000) begin bad++; $display("FAIL rms_async_holds: got %b expected 000", {hold_all, hold_front, bubble_ex}); end
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL rms_async_fwd: got %b expected 00", fwd_a); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL rms_async_count: got %0d expected 0", stall_count); end
    tick();
    clear_inputs();
    id_valid = 1; id_sr2 = 3'd6; id_sr2_used = 1;
    reset_n = 1;
    #1;
    total++; if (hold_front !== 1'b0) begin bad++; $display("FAIL rms_release: got %b expected 0", hold_front); end
    tick();
    total++; if ({hold_front, bubble_ex} !== 2'b00) begin bad++; $display("FAIL rms_back_in_run: got %b expected 00", {hold_front, bubble_ex}); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL rms_count: got %0d expected 0", stall_count); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_hist();
    test_load_use();
    test_mem_busy();
    test_saturation();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline's combinational forwarding logic.
- Combines operand forwarding, load-use stall sequencing with a configurable load-to-use latency, and a memory-wait freeze.
- Adds a one-entry writeback-history bypass for register files without write-through, plus a saturating stall-cycle performance counter.
- Sits beside the ID/EX boundary and drives the ALU operand muxes and the pipeline-register enables.

Parameters:
- REG_W, 3, width of a register specifier (8 GPRs).
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (range 1..7).
- RF_WRITE_THROUGH, 0, 1 = regfile bypasses its own write, so the WB-history source is disabled.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- ex_sr1, ex_sr2  in  REG_W  sources of the instruction in EX
- ex_sr1_used, ex_sr2_used  in  1  operand actually read; decoded by control, e.g. sr2_used=0 for ADD/AND immediate mode
- id_valid  in  1  ID stage holds a real instruction
- id_sr1, id_sr2, id_sr1_used, id_sr2_used  in  REG_W/1  sources of the instruction in ID
- idex_write, idex_is_load  in  1  the instruction in EX writes a register / is a load
- idex_dest  in  REG_W
- exmem_write, exmem_is_load  in  1
- exmem_dest  in  REG_W
- memwb_write  in  1
- memwb_dest  in  REG_W
- mem_busy  in  1  memory stage is waiting on a cache/memory response
- perf_clr  in  1  synchronous clear of stall_count
- fwd_a, fwd_b  out  2  operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 WB-history
- hold_front  out  1  freeze PC and IF/ID
- bubble_ex  out  1  load NOP into ID/EX
- hold_all  out  1  freeze all pipeline registers
- stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset: while reset_n=0 all outputs are forced to 0; state=RUN, lu_cnt=0, hist_valid=0, stall_count=0.

Forwarding (combinational, per operand X in {a,b} with source srcX and flag srcX_used):
- If srcX_used=0, select 00.
- Priority from highest: EX/MEM (exmem_write && !exmem_is_load && exmem_dest==srcX) -> 10.
- Then MEM/WB (memwb_write && memwb_dest==srcX) -> 01.
- Then WB-history (RF_WRITE_THROUGH==0 && hist_valid && hist_dest==srcX) -> 11.
- Otherwise 00.

WB-history register (sequential):
- On each clk with hold_all=0: hist_valid<=memwb_write, hist_dest<=memwb_dest.
- Held while hold_all=1.

Load-use hazard (combinational):
- lu_hit = id_valid && idex_write && idex_is_load && ((id_sr1_used && id_sr1==idex_dest) || (id_sr2_used && id_sr2==idex_dest)).

FSM, states RUN and LU_WAIT:
- mem_busy=1 overrides in any state: hold_all=1, hold_front=0, bubble_ex=0. State and lu_cnt are frozen.
- RUN, no lu_hit: all holds 0.
- RUN, lu_hit: hold_front=1, bubble_ex=1. If LOAD_USE_CYCLES>1, lu_cnt<=LOAD_USE_CYCLES-2 and go to LU_WAIT; else stay in RUN.
- LU_WAIT: hold_front=1, bubble_ex=1. If lu_cnt==0 go to RUN, else lu_cnt<=lu_cnt-1.
- A new lu_hit is not re-evaluated during LU_WAIT.
- Total bubbles per hazard = LOAD_USE_CYCLES exactly.

Perf counter:
- perf_clr has priority and sets the counter to 0.
- Otherwise the counter increments when hold_front||hold_all and saturates at all-ones.

Reset mid-stall:
- Outputs drop to 0 immediately (asynchronous) and the FSM returns to RUN. Any partial bubble sequence is abandoned.

Decomposition:
- lc3b_types supplies lc3b_reg.
- Add to lc3b_types: enum fwd_sel_t {FWD_RF, FWD_MEMWB, FWD_EXMEM, FWD_HIST} and enum hz_state_t {HZ_RUN, HZ_LU_WAIT}.
- One sub-module, fwd_select: the per-operand priority mux, instantiated twice.

Test Plan:
- EX/MEM and MEM/WB both write R3; EX reads sr1=R3 and sr2=R3 with both used -> fwd_a=10, fwd_b=10.
- ADD immediate (sr2_used=0); MEM/WB writes sr2 register -> fwd_b=00. Same case with sr2_used=1 -> fwd_b=01.
- LOAD_USE_CYCLES=3, LDR R2 in EX, ID reads R2 -> hold_front=bubble_ex=1 for exactly 3 cycles, then 0; stall_count=3.
- mem_busy raised in the second bubble cycle for 4 cycles -> hold_all=1, hold_front=0 for 4 cycles, then the remaining 2 bubbles complete; stall_count=7.
- RF_WRITE_THROUGH=0: R5 written back at cycle n, EX reads R5 at n+1 with no newer writer -> fwd_a=11. With RF_WRITE_THROUGH=1 -> 00.
- reset_n pulsed low during LU_WAIT -> all outputs 0 asynchronously; after release with no hazard, hold_front=0 and stall_count=0.
